uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
// - UART transmitter: serialises one byte per valid/ready handshake onto txd, LSB first, start + 8 data + opt parity + 1/2 stop.
// - Counterpart of uart_rx on the same link; default 8N1 frame is received bit-exact by uart_rx at matching p_sys_clk/p_baud_rate.
// - Sits between a byte producer (CPU/FIFO/test logic) and the txd pad; idles high.
// PARAMETERS
// - p_sys_clk    50_000_000  system clock frequency, Hz
// - p_baud_rate  115200      line rate, bit/s; bit period l_baud_div = p_sys_clk/p_baud_rate (truncating, 434 at defaults)
// - p_parity     0           0 none, 1 odd, 2 even; parity computed over the 8 data bits
// - p_stop_bits  1           1 or 2 stop bits
// PORTS
// - clk       in   1  system clock, rising edge
// - rst       in   1  reset, asynchronous, active-high
// - tx_valid  in   1  producer has a byte on tx_data
// - tx_data   in   8  byte to send, sampled only at acceptance
// - tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready at a rising clk edge
// - txd       out  1  serial line, registered, idle 1
// - busy      out  1  high from the edge after acceptance until return to IDLE
// - done      out  1  one-cycle pulse in the first IDLE cycle after the last stop bit
// BEHAVIOUR
// - Reset (async, any state): state IDLE, txd=1, busy=0, done=0, counters 0; tx_ready=1 once reset deasserts.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE  -> START on accept: latch tx_data into shift reg, txd<=0, baud_cnt<=0, bit_cnt<=0 on that same edge.
//   START -> DATA after l_baud_div cycles; DATA shifts right, txd<=shift[0], 8 bits, bit_cnt 0..7.
//   DATA  -> PARITY (p_parity!=0) else STOP after bit 7's full period; PARITY txd = ^data (even) / ~^data (odd).
//   STOP  txd=1 for p_stop_bits*l_baud_div cycles -> IDLE, done<=1 on that edge.
// - Every bit held exactly l_baud_div clk cycles; baud_cnt counts 0..l_baud_div-1, wraps on bit advance.
// - Latency: txd falls on the edge that samples the handshake; 8N1 frame = 10*l_baud_div cycles (4340 at defaults).
// - tx_ready combinational = (state==IDLE); tx_valid while busy ignored, tx_data changes after accept ignored.
// - Back-to-back: tx_ready and done both high in the first IDLE cycle; accept there is legal, giving exactly 1 idle
//   clk between stop end and next start; frame start spacing 10*l_baud_div+1 cycles (8N1).
// - done and an accept in the same cycle: done still pulses exactly once, new frame starts normally.
// - Reset mid-frame: txd returns to 1 immediately, in-flight byte discarded, no done pulse.
// - Widths: baud_cnt 16 bits, bit_cnt 3 bits; elaboration error if l_baud_div < 2 or > 65535, or p_parity/p_stop_bits illegal.
// STRUCTURE
// - Shared package uart_pkg: FSM state encoding, parity codes (NONE/ODD/EVEN), baud divisor function
//   p_sys_clk/p_baud_rate, reused by uart_rx-side updates.
// - One sub-module: uart_tx_baud_tick - l_baud_div divider, synchronous clear on frame start, emits bit_end tick
//   in the last cycle of each bit period; FSM, shift reg and txd register stay in uart_tx.
// TESTING (defaults unless stated, l_baud_div=434)
// - Reset, hold tx_valid=0 for 2000 clk -> txd=1, tx_ready=1, busy=0, done=0 throughout.
// - Send 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each exactly 434 clk; done pulses once 4340 clk after accept edge.
// - tx_valid held with 0xA5 then 0x3C -> second start bit falls 4341 clk after first; busy low exactly 1 clk between.
// - Loopback txd->uart_rx.rxd, bytes 0x00..0xFF -> 256 uart_rx done pulses, each data equal to byte sent.
// - Assert rst during data bit 3 of 0xF0 -> txd=1 same cycle, no done; after release send 0x81 -> clean frame.
// - p_parity=2, p_stop_bits=2, send 0x07 -> parity bit 1, txd high 868 clk before done; p_parity=1 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and the baud divisor
// helper, used by both the transmitter and receiver sides of the link.
package uart_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Parity selection codes
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clock cycles per bit; truncating so both link ends derive the same period
   function automatic int baud_div(input int sys_clk, input int baud_rate);
      return sys_clk / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period divider for the transmitter. Held at zero while clr_i is high so a
// frame starting on the accept edge gets a full first bit period; bit_end_o
// marks the last cycle of each bit period.
module uart_tx_baud_tick #(
   parameter int p_div = 434
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic bit_end_o
);

   localparam logic [15:0] L_LAST = 16'(p_div - 1);

   logic [15:0] cnt_q, cnt_d;

   // Next count: clear, wrap at the end of a bit, otherwise advance
   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (clr_i || (cnt_q == L_LAST)) begin
         cnt_d = 16'd0;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = (cnt_q == L_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB first as
// start + 8 data + optional parity + 1 or 2 stop bits. txd idles high.
module uart_tx
   import uart_pkg::*;
#(
   parameter int p_sys_clk   = 50_000_000,
   parameter int p_baud_rate = 115200,
   parameter int p_parity    = 0,
   parameter int p_stop_bits = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tx_valid_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o,
   output logic       txd_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int         L_BAUD_DIV  = baud_div(p_sys_clk, p_baud_rate);
   localparam logic       L_HAS_PAR   = (p_parity != PAR_NONE);
   localparam logic       L_PAR_ODD   = (p_parity == PAR_ODD);
   localparam logic [2:0] L_STOP_LAST = 3'(p_stop_bits - 1);

   if ((L_BAUD_DIV < 2) || (L_BAUD_DIV > 65535)) begin : g_bad_div
      $error("uart_tx: baud divisor %0d outside 2..65535", L_BAUD_DIV);
   end
   if ((p_parity < 0) || (p_parity > 2)) begin : g_bad_parity
      $error("uart_tx: p_parity %0d must be 0, 1 or 2", p_parity);
   end
   if ((p_stop_bits != 1) && (p_stop_bits != 2)) begin : g_bad_stop
      $error("uart_tx: p_stop_bits %0d must be 1 or 2", p_stop_bits);
   end

   uart_state_e state_q;
   logic [7:0]  shift_q;
   logic        par_q;      // XOR of the accepted byte
   logic [2:0]  bit_cnt_q;  // data bit index, reused to count stop bits
   logic        txd_q;
   logic        busy_q;
   logic        done_q;
   logic        accept;
   logic        bit_end;

   assign tx_ready_o = (state_q == ST_IDLE);
   assign accept     = tx_valid_i && tx_ready_o;

   // Divider is held clear in IDLE, so the accept edge starts a fresh period
   uart_tx_baud_tick #(
      .p_div(L_BAUD_DIV)
   ) u_baud (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tx_ready_o),
      .bit_end_o(bit_end)
   );

   // Frame sequencer: advances one bit per bit_end, drives registered txd/busy/done
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         shift_q   <= 8'd0;
         par_q     <= 1'b0;
         bit_cnt_q <= 3'd0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q   <= ST_START;
                  shift_q   <= tx_data_i;
                  par_q     <= ^tx_data_i;
                  bit_cnt_q <= 3'd0;
                  txd_q     <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state_q   <= ST_DATA;
                  txd_q     <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= 3'd0;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_q <= 3'd0;
                     if (L_HAS_PAR) begin
                        state_q <= ST_PARITY;
                        txd_q   <= par_q ^ L_PAR_ODD;
                     end else begin
                        state_q <= ST_STOP;
                        txd_q   <= 1'b1;
                     end
                  end else begin
                     txd_q     <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state_q   <= ST_STOP;
                  txd_q     <= 1'b1;
                  bit_cnt_q <= 3'd0;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (bit_cnt_q == L_STOP_LAST) begin
                     state_q   <= ST_IDLE;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     bit_cnt_q <= 3'd0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign txd_o  = txd_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1 default, 8E2 default clocks, 8O1 with
// a short bit period). One DUT is active at a time; stimulus pushes expected
// bytes with their start cycle, a monitor decodes txd against a frame model.
module tb_uart_tx;

   localparam int LIM = 20000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       tx_valid = '0;
   logic [2:0][7:0]  tx_data  = '0;
   wire  [2:0]       tx_ready, txd, busy, done;

   int sel = 0, cyc = 0, tests = 0, fails = 0, idle_bad = 0;
   int dn[3] = '{0, 0, 0};

   typedef struct {
      logic [7:0] d;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];
   int   starts[$];

   uart_tx u_a (
      .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid[0]), .tx_data_i(tx_data[0]),
      .tx_ready_o(tx_ready[0]), .txd_o(txd[0]), .busy_o(busy[0]), .done_o(done[0]));

   uart_tx #(.p_parity(2), .p_stop_bits(2)) u_b (
      .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid[1]), .tx_data_i(tx_data[1]),
      .tx_ready_o(tx_ready[1]), .txd_o(txd[1]), .busy_o(busy[1]), .done_o(done[1]));

   uart_tx #(.p_sys_clk(1200), .p_baud_rate(100), .p_parity(1)) u_c (
      .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid[2]), .tx_data_i(tx_data[2]),
      .tx_ready_o(tx_ready[2]), .txd_o(txd[2]), .busy_o(busy[2]), .done_o(done[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (done[i] === 1'b1) dn[i] <= dn[i] + 1;
   end

   // ---- reference model -------------------------------------------------
   function automatic int div_of(input int s);
      return (s == 2) ? 1200 / 100 : 50_000_000 / 115200;
   endfunction
   function automatic int par_of(input int s);
      return (s == 0) ? 0 : ((s == 1) ? 2 : 1);
   endfunction
   function automatic int stops_of(input int s);
      return (s == 1) ? 2 : 1;
   endfunction
   function automatic int nbits_of(input int s);
      return 10 + ((par_of(s) != 0) ? 1 : 0) + (stops_of(s) - 1);
   endfunction
   // Line levels, index = bit position in frame; unused upper positions are stop level
   function automatic logic [11:0] frame_of(input int s, input logic [7:0] d);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (par_of(s) == 2) f[9] = (($countones(d) % 2) == 1);
      else if (par_of(s) == 1) f[9] = (($countones(d) % 2) == 0);
      return f;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ---- monitor ---------------------------------------------------------
   initial begin : mon
      exp_t        e;
      logic [11:0] f;
      logic [3:0]  act, expv;
      logic        ok;
      bit          ab;
      int          dv;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (txd[sel] === 1'b0) begin
            starts.push_back(cyc);
            chk("expected frame queued", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin e.d = 8'h00; e.cyc = cyc; end
            chk($sformatf("dut%0d byte %02h start cycle", sel, e.d), cyc, e.cyc);
            f  = frame_of(sel, e.d);
            dv = div_of(sel);
            ab = 1'b0;
            for (int k = 0; k < nbits_of(sel) && !ab; k++) begin
               ok   = 1'b1;
               expv = {3'b100, f[k]};   // busy=1 ready=0 done=0 txd=model
               act  = 4'hx;
               for (int c = 0; c < dv; c++) begin
                  if (k != 0 || c != 0) @(negedge clk);
                  if (rst) begin ab = 1'b1; break; end
                  if (ok) begin
                     act = {busy[sel], tx_ready[sel], done[sel], txd[sel]};
                     ok  = (act === expv);
                  end
               end
               if (!ab) chk($sformatf("dut%0d byte %02h bit %0d {busy,ready,done,txd}", sel, e.d, k),
                            int'(act), int'(expv));
            end
            if (!ab) begin
               @(negedge clk);
               if (!rst)
                  chk($sformatf("dut%0d byte %02h frame end {busy,ready,done,txd}", sel, e.d),
                      int'({busy[sel], tx_ready[sel], done[sel], txd[sel]}), 4'b0111);
            end
         end else if (busy[sel] !== 1'b0 || done[sel] !== 1'b0 || tx_ready[sel] !== 1'b1) begin
            idle_bad++;
         end
      end
   end

   // ---- stimulus helpers (called aligned to a falling clk edge) -------------
   task automatic send(input logic [7:0] d, input bit hold, input bit junk);
      int n = 0;
      tx_valid[sel] = 1'b1;
      tx_data[sel]  = d;
      while (tx_ready[sel] !== 1'b1 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("dut%0d tx_ready within bound", sel), int'(tx_ready[sel]), 1);
      if (tx_ready[sel] !== 1'b1) begin
         tx_valid[sel] = 1'b0;
         return;
      end
      exp_q.push_back('{d, cyc + 1});
      @(negedge clk);
      if (!hold) tx_valid[sel] = 1'b0;
      if (junk) begin
         for (int j = 0; j < nbits_of(sel) * div_of(sel) - 2; j++) begin
            tx_valid[sel] = 1'($urandom);
            tx_data[sel]  = 8'($urandom);
            @(negedge clk);
         end
         tx_valid[sel] = 1'b0;
      end
   endtask

   task automatic wait_done(input int t);
      int n = 0;
      while (dn[sel] < t && n < LIM) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk($sformatf("dut%0d done pulse count", sel), dn[sel], t);
   endtask

   // ---- main sequence ---------------------------------------------------
   initial begin : stim
      int bad;
      repeat (3) @(negedge clk);
      chk("reset txd", int'(txd[0]), 1);
      chk("reset busy", int'(busy[0]), 0);
      chk("reset done", int'(done[0]), 0);
      rst = 1'b0;

      // idle line after reset
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if ({busy[0], done[0], tx_ready[0], txd[0]} !== 4'b0011) bad++;
      end
      chk("idle 2000 clk bad cycles", bad, 0);

      // single 8N1 frame
      send(8'h55, 1'b0, 1'b0);
      wait_done(1);

      // back-to-back with tx_valid held
      starts.delete();
      send(8'hA5, 1'b1, 1'b0);
      send(8'h3C, 1'b0, 1'b0);
      wait_done(3);
      chk("back-to-back frames seen", starts.size(), 2);
      if (starts.size() >= 2)
         chk("back-to-back start spacing", starts[1] - starts[0], 10 * div_of(0) + 1);

      // reset during data bit 3
      send(8'hF0, 1'b0, 1'b0);
      repeat (4 * div_of(0) + 100) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid-frame reset txd", int'(txd[0]), 1);
      chk("mid-frame reset busy", int'(busy[0]), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("no done after mid-frame reset", dn[0], 3);
      send(8'h81, 1'b0, 1'b0);
      wait_done(4);

      // even parity, two stop bits
      sel = 1;
      @(negedge clk);
      send(8'h07, 1'b0, 1'b0);
      wait_done(1);
      send(8'($urandom), 1'b0, 1'b0);
      wait_done(2);

      // odd parity, short bit period, random bytes and gaps, junk while busy
      sel = 2;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(8'($urandom), 1'b0, 1'b1);
      end
      wait_done(40);

      chk("idle-state violations", idle_bad, 0);
      chk("unconsumed expectations", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got time limit reached, expected sequence completion");
      $fatal(1, "watchdog expired");
   end

endmodule
